// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
package serial_adder_pkg;

    // State encodings.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StDone = DONE
    } state_e;

    // Step counter width: clog2(steps), but never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from full-adder cells.
module serial_adder_digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb   // carry into the top bit, for signed overflow
);

    logic [DIGIT:0] c;

    // Ripple the carry through one full-adder cell per bit.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        co    = c[DIGIT];
        c_msb = c[DIGIT-1];
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor processing DIGIT bits per clock with a registered carry.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dsum;
    logic             dco;
    logic             dcmsb;

    serial_adder_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .sum   (dsum),
        .co    (dco),
        .c_msb (dcmsb)
    );

    // Next-state logic: operand capture on accepted start, one digit per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                // New digit enters at the top so the LSB digit ends up at bit 0.
                s_d     = (s_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                carry_d = dco;
                if (cnt_q == LAST) begin
                    cout_d  = dco;
                    ovf_d   = dco ^ dcmsb;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, random ops, corner sequences.
module tb_serial_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIGIT = 4;
    localparam int unsigned STEPS = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, start2;
    logic             sub, cin;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, cout, ovf;
    logic [WIDTH-1:0] s;
    logic             busy2, done2, cout2, ovf2;
    logic [WIDTH-1:0] s2;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    serial_adder #(.WIDTH(WIDTH), .DIGIT(WIDTH)) dut_wide (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy2),
        .done  (done2),
        .s     (s2),
        .cout  (cout2),
        .ovf   (ovf2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic        vsub;
        logic [15:0] es;
        logic        ecout;
        logic        eovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic, {cout, ovf, sum}.
    function automatic logic [17:0] ref_model(input logic [15:0] ra, rb,
                                              input logic rcin, rsub);
        logic [15:0] bb;
        logic [16:0] full;
        logic        c0, v;
        bb   = rsub ? ~rb : rb;
        c0   = rsub ? 1'b1 : rcin;
        full = {1'b0, ra} + {1'b0, bb} + {16'd0, c0};
        v    = (ra[15] == bb[15]) && (full[15] != ra[15]);
        return {full[16], v, full[15:0]};
    endfunction

    // Issue one op at posedge+1; returns in the Done cycle. glitch>=0 pulses start mid-RUN.
    task automatic run_op(input logic [15:0] ia, ib, input logic icin, isub, input int glitch,
                          input logic [15:0] es, input logic ecout, eovf);
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < int'(STEPS); i++) begin
            check("busy_window", {30'd0, busy, done}, 32'b10);
            if (i == glitch) begin
                a = 16'($urandom); b = 16'($urandom); cin = ~cin; sub = ~sub;
                start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("done_pulse", {30'd0, busy, done}, 32'b01);
        check("sum", {16'd0, s}, {16'd0, es});
        check("cout", {31'd0, cout}, {31'd0, ecout});
        check("ovf", {31'd0, ovf}, {31'd0, eovf});
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_done", {30'd0, busy, done}, 32'b00);
    endtask

    vec_t        vecs[7];
    logic [17:0] r;
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic        saw_done;

    initial begin
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[6] = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {s, 13'd0, cout, ovf, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_wide", {s2, 13'd0, cout2, ovf2, busy2 | done2}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, -1,
                   vecs[i].es, vecs[i].ecout, vecs[i].eovf);
            idle_cycle();
        end

        // Subtract then back-to-back add accepted in DONE.
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, -1, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h0001, 16'h0001, 1'b1, 1'b0, -1, 16'h0003, 1'b0, 1'b0);
        idle_cycle();

        // Start pulsed mid-RUN with other operands must be ignored.
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1, 16'h3333, 1'b0, 1'b0);
        idle_cycle();

        // Random operations with optional glitches and back-to-back issue.
        for (int n = 0; n < 60; n++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            r  = ref_model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, STEPS - 1)),
                   r[15:0], r[17], r[16]);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        // Reset during step 2: outputs clear at once and no Done follows.
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, -1, 16'h8000, 1'b0, 1'b1);
        idle_cycle();
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {s, 13'd0, cout, ovf, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("no_done_after_abort", {31'd0, saw_done}, 32'd0);

        // Full-width digit: Done one cycle after Start.
        for (int n = 0; n < 6; n++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            r  = ref_model(ra, rb, rc, rs);
            a = ra; b = rb; cin = rc; sub = rs; start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            check("wide_busy", {30'd0, busy2, done2}, 32'b10);
            @(posedge clk); #1;
            check("wide_done", {30'd0, busy2, done2}, 32'b01);
            check("wide_result", {13'd0, cout2, ovf2, s2}, {13'd0, r[17], r[16], r[15:0]});
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor that adds two `WIDTH`-bit operands `DIGIT` bits per clock, rippling the carry through a registered carry flop between digits. It extends the lab's single-bit adder primitives to a sequential, handshaked arithmetic unit. Datapath blocks use it when a full-width combinational carry chain is too long or too large. Operands are captured on `Start`, and the result is held stable after `Done` until the next accepted `Start`.

## Interface
- `WIDTH`, 16: operand/result width; must be a multiple of `DIGIT`.
- `DIGIT`, 4: bits processed per cycle; 1 ≤ `DIGIT` ≤ `WIDTH`.
- `Clk` input 1: single clock; all state changes on the rising edge.
- `Rst_n` input 1: reset, asynchronous, active-low.
- `Start` input 1: request; sampled only in IDLE or DONE.
- `Sub` input 1: 0 = add, 1 = subtract; latched with the operands.
- `A` input `WIDTH`: operand A; latched on an accepted `Start`.
- `B` input `WIDTH`: operand B; latched on an accepted `Start`.
- `Cin` input 1: carry-in for add; ignored when `Sub`=1; latched.
- `Busy` output 1: high while in RUN.
- `Done` output 1: one-cycle pulse when the result is complete.
- `S` output `WIDTH`: result register.
- `Cout` output 1: carry out of the MSB. In subtract mode, 1 = no borrow.
- `Ovf` output 1: two's-complement signed overflow.

## Operation
- `STEPS` = `WIDTH`/`DIGIT`.
- Add: S = A + B + Cin. Subtract: S = A + ~B + 1.
- FSM states:
  - IDLE → RUN on `Start`.
  - RUN → DONE after `STEPS` digit steps.
  - DONE → RUN if `Start`, else → IDLE.
- On an accepted `Start`:
  - latch A, B (inverted if `Sub`), and the carry flop = `Sub` ? 1 : `Cin`;
  - clear the step counter.
- Each RUN cycle:
  - add the low `DIGIT` bits of the A and B shift registers plus the carry flop;
  - shift both operand registers right by `DIGIT`;
  - shift `S` right by `DIGIT`, inserting the digit sum at the top;
  - store the digit carry-out in the carry flop.
- On the final step:
  - `Cout` = carry out of the MSB;
  - `Ovf` = (carry into MSB) XOR (carry out of MSB);
  - `Done` asserts.
- `S` holds intermediate values during RUN and is valid only from `Done` until the next accepted `Start`. `Cout`/`Ovf` update only on the final step.
- `Start` during RUN is ignored and does not disturb the operation.
- `Start` in DONE is accepted (back-to-back operation).

## Timing
- Reset (async assert, any state):
  - state = IDLE;
  - `S`=0, `Cout`=0, `Ovf`=0, `Busy`=0, `Done`=0;
  - the carry flop, operand registers and step counter are cleared.
- Reset mid-RUN aborts the operation: no `Done` is issued.
- Deassertion is synchronous to `Clk` (externally synchronised).
- `Start` sampled at edge k:
  - `Busy`=1 from after edge k to after edge k+`STEPS`;
  - `Done`=1 for exactly the cycle after edge k+`STEPS`;
  - `S`/`Cout`/`Ovf` are final in that same cycle.
- Latency is `STEPS` cycles. Maximum throughput is one result per `STEPS`+1 cycles; with back-to-back `Start` in DONE, `Busy` rises again in the cycle after `Done`.
- `DIGIT`=`WIDTH`: `STEPS`=1, so `Done` arrives one cycle after `Start`.

## Structure
- Package `serial_adder_pkg`:
  - state encoding localparams IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - a function computing counter width as clog2(`STEPS`), minimum 1.
- Sub-module `digit_adder`: combinational `DIGIT`-bit ripple of full-adder cells. Outputs are the digit sum, carry-out, and carry into the top bit (used for `Ovf`).
- The top level contains the FSM, step counter, operand and result shift registers, and the carry flop.

## Test plan
WIDTH=16, DIGIT=4 unless noted.
- A=16'h00FF, B=16'h0001, Cin=0, Sub=0 → `Done` 4 cycles after `Start`; S=16'h0100, Cout=0, Ovf=0; `Busy` high for exactly 4 cycles.
- A=16'hFFFF, B=16'h0001, Cin=0 → S=16'h0000, Cout=1, Ovf=0.
- A=16'h7FFF, B=16'h0001, Cin=0 → S=16'h8000, Cout=0, Ovf=1.
- A=16'h0005, B=16'h0007, Sub=1, Cin=1 → S=16'hFFFE, Cout=0, Ovf=0; then A=16'h0001, B=16'h0001, Cin=1, Sub=0 issued back-to-back in DONE → S=16'h0003.
- `Start` pulsed again mid-RUN with different operands → ignored; original result delivered on schedule.
- `Rst_n` low during step 2 → all outputs 0 immediately, no `Done`. DIGIT=16 build: `Done` one cycle after `Start`.
